// File: rtl/serial_tx_if.sv
// serial_tx_if: parallel word handshake plus registered serial output bundle for serial_tx.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_o;
    logic              tx_valid_o;
    logic              tx_last_o;
    logic              busy_o;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx_o, tx_valid_o, tx_last_o, busy_o
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx_o, tx_valid_o, tx_last_o, busy_o
    );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: LSB-first parallel-to-serial framer with optional even parity and back-to-back frames.
module serial_tx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input logic       clk,
    input logic       reset,
    serial_tx_if.slave bus
);
    localparam int F  = DATA_W + PARITY_EN;
    localparam int CW = $clog2(F);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [F-1:0]  sh, sh_d, frame;
    logic          tx, tx_d, vld, vld_d, lst, lst_d, bsy, bsy_d;
    logic          at_last, ready, accept;

    // The cast drops the parity bit when PARITY_EN is 0.
    assign frame   = F'({^bus.in_data, bus.in_data});
    assign at_last = (state == SHIFT) && (cnt == CW'(F - 1));
    assign ready   = !reset && ((state == IDLE) || at_last);
    assign accept  = bus.in_valid && ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        tx_d    = tx;
        vld_d   = vld;
        lst_d   = lst;
        bsy_d   = bsy;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = frame >> 1;
            tx_d    = frame[0];
            vld_d   = 1'b1;
            lst_d   = 1'b0;
            bsy_d   = 1'b1;
        end else if (at_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            tx_d    = 1'b0;
            vld_d   = 1'b0;
            lst_d   = 1'b0;
            bsy_d   = 1'b0;
        end else if (state == SHIFT) begin
            cnt_d = cnt + CW'(1);
            sh_d  = sh >> 1;
            tx_d  = sh[0];
            lst_d = (cnt == CW'(F - 2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            tx    <= 1'b0;
            vld   <= 1'b0;
            lst   <= 1'b0;
            bsy   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sh    <= sh_d;
            tx    <= tx_d;
            vld   <= vld_d;
            lst   <= lst_d;
            bsy   <= bsy_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.tx_o       = tx;
    assign bus.tx_valid_o = vld;
    assign bus.tx_last_o  = lst;
    assign bus.busy_o     = bsy;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: random and directed stimulus on a plain and a parity instance, checked against a bit-queue model.
module tb_serial_tx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_tx_if #(.DATA_W(W)) bus0 ();
    serial_tx_if #(.DATA_W(W)) bus1 ();

    serial_tx #(.DATA_W(W), .PARITY_EN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    serial_tx #(.DATA_W(W), .PARITY_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int total = 0;
    int bad = 0;

    // Model: per instance, the bits still to appear on tx_o; the head is the bit on the line now.
    bit         q[2][64];
    int         qh[2];
    int         qn[2];
    logic [W-1:0] src[2][32];
    int         src_n[2];
    int         src_i[2];
    bit         hold;
    logic [15:0] cap[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int d, input logic [W-1:0] w);
        for (int k = 0; k < W + d; k++) begin
            q[d][(qh[d] + qn[d]) % 64] = (k < W) ? w[k] : ^w;
            qn[d]++;
        end
    endtask

    task automatic outs(input int d, output logic [4:0] o);
        o = d ? {bus1.tx_o, bus1.tx_valid_o, bus1.tx_last_o, bus1.busy_o, bus1.in_ready}
              : {bus0.tx_o, bus0.tx_valid_o, bus0.tx_last_o, bus0.busy_o, bus0.in_ready};
    endtask

    task automatic check_idle(input string tag, input logic rdy);
        logic [4:0] o;
        for (int d = 0; d < 2; d++) begin
            outs(d, o);
            check($sformatf("%s_out%0d", tag, d), {28'd0, o[4:1]}, 32'd0);
            check($sformatf("%s_rdy%0d", tag, d), {31'd0, o[0]}, {31'd0, rdy});
        end
    endtask

    task automatic tick();
        logic [4:0] o;
        logic       v;
        logic [W-1:0] data;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            outs(d, o);
            check($sformatf("tx%0d", d), {31'd0, o[4]}, {31'd0, qn[d] > 0 ? q[d][qh[d]] : 1'b0});
            check($sformatf("valid%0d", d), {31'd0, o[3]}, {31'd0, qn[d] > 0});
            check($sformatf("last%0d", d), {31'd0, o[2]}, {31'd0, qn[d] == 1});
            check($sformatf("busy%0d", d), {31'd0, o[1]}, {31'd0, qn[d] > 0});
            check($sformatf("ready%0d", d), {31'd0, o[0]}, {31'd0, qn[d] <= 1});
            if (o[3]) cap[d] = {o[4], cap[d][15:1]};
            v = (src_i[d] < src_n[d]) && (hold || ($urandom_range(0, 1) == 1));
            data = v ? src[d][src_i[d]] : W'($urandom);
            if (d == 0) begin
                bus0.in_valid = v;
                bus0.in_data  = data;
            end else begin
                bus1.in_valid = v;
                bus1.in_data  = data;
            end
            if (qn[d] > 0) begin
                qh[d] = (qh[d] + 1) % 64;
                qn[d]--;
            end
            if (v && qn[d] == 0) begin
                push_word(d, data);
                src_i[d]++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            tick();
            n++;
        end while (n < 400 && (src_i[0] < src_n[0] || src_i[1] < src_n[1] || qn[0] > 0 || qn[1] > 0));
        check("drain_timeout", {31'd0, n >= 400}, 32'd0);
        tick();
    endtask

    task automatic load2(input logic [W-1:0] a0, input logic [W-1:0] b0, input int n0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input int n1);
        src[0][0] = a0; src[0][1] = b0; src_n[0] = n0; src_i[0] = 0;
        src[1][0] = a1; src[1][1] = b1; src_n[1] = n1; src_i[1] = 0;
    endtask

    initial begin
        qh = '{0, 0}; qn = '{0, 0}; src_n = '{0, 0}; src_i = '{0, 0}; cap = '{16'd0, 16'd0};
        hold = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        #3 check_idle("reset", 1'b0);
        #9 reset = 1'b0;
        #1 check_idle("release", 1'b1);

        load2(8'hA5, 8'h00, 1, 8'h07, 8'h00, 1);
        drain();
        check("a5_bits", {24'd0, cap[0][15:8]}, 32'h0000_00A5);
        check("parity07_bits", {23'd0, cap[1][15:7]}, 32'h0000_0107);

        load2(8'h01, 8'h80, 2, 8'h01, 8'h80, 2);
        drain();
        check("b2b_bits", {16'd0, cap[0]}, 32'h0000_8001);

        load2(8'h3C, 8'hFF, 2, 8'hC3, 8'hFF, 2);
        drain();
        check("holdoff_ff", {24'd0, cap[0][15:8]}, 32'h0000_00FF);

        for (int r = 0; r < 6; r++) begin
            hold = ($urandom_range(0, 1) == 1);
            for (int d = 0; d < 2; d++) begin
                src_n[d] = $urandom_range(1, 12);
                src_i[d] = 0;
                for (int i = 0; i < src_n[d]; i++) src[d][i] = W'($urandom);
            end
            drain();
        end

        hold = 1'b1;
        load2(W'($urandom), 8'h00, 1, W'($urandom), 8'h00, 1);
        repeat (5) tick();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_idle("async_rst", 1'b0);
        qn = '{0, 0}; src_n = '{0, 0};
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle("post_rst", 1'b1);
        repeat (5) tick();

        for (int d = 0; d < 2; d++) begin
            src_n[d] = 4;
            src_i[d] = 0;
            for (int i = 0; i < 4; i++) src[d][i] = W'($urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of the parallel word; legal range 2..32.
REQ-002 Parameter PARITY_EN, default 0: 1 appends one even-parity bit after the data bits; 0 sends data bits only.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  parallel word on in_data is offered.
REQ-006 in_data  input  DATA_W  parallel word to serialize.
REQ-007 in_ready  output  1  block accepts in_data on this edge if in_valid=1.
REQ-008 tx_o  output  1  serial data bit, registered.
REQ-009 tx_valid_o  output  1  tx_o carries a frame bit this cycle, registered.
REQ-010 tx_last_o  output  1  current tx_o bit is the final bit of the frame, registered.
REQ-011 busy_o  output  1  a frame is in progress, registered.

Function
REQ-012 Frame length F SHALL be DATA_W+PARITY_EN bits; the bit counter SHALL be wide enough to hold 0..F-1.
REQ-013 State machine SHALL have two states: IDLE and SHIFT.
REQ-014 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; in_data SHALL be captured into the shift register on that edge.
REQ-015 in_ready SHALL be 1 in IDLE and 1 in SHIFT when the counter equals F-1 (last bit); 0 otherwise.
REQ-016 IDLE -> SHIFT on accept; SHIFT -> IDLE when the counter equals F-1 and no accept occurs; SHIFT -> SHIFT with counter reset to 0 when the counter equals F-1 and an accept occurs (back-to-back).
REQ-017 Bits SHALL be sent LSB first: after accept on edge N, tx_o = in_data[0] during cycle N+1 and in_data[k] during cycle N+1+k.
REQ-018 With PARITY_EN=1, the bit in cycle N+1+DATA_W SHALL equal the XOR of all captured data bits (even parity).
REQ-019 tx_valid_o and busy_o SHALL be 1 for exactly F consecutive cycles per frame, starting in cycle N+1.
REQ-020 tx_last_o SHALL be 1 only during the final bit of each frame.
REQ-021 In IDLE, tx_o, tx_valid_o, tx_last_o and busy_o SHALL be 0.
REQ-022 Back-to-back frames: bit 0 of the next frame SHALL appear in the cycle immediately after the previous frame's last bit, with no idle gap; tx_valid_o stays 1.
REQ-023 in_data changes while not accepted SHALL NOT affect the frame in flight.
REQ-024 in_valid=1 while in_ready=0 SHALL be held off with no data loss; the word is accepted on the first edge where in_ready=1.
REQ-025 Latency from accept edge to first bit SHALL be exactly 1 cycle.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, force state IDLE, counter 0, shift register 0, and tx_o=0, tx_valid_o=0, tx_last_o=0, busy_o=0.
REQ-027 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-028 Reset mid-frame SHALL abort the frame; no remaining bits are sent after deassertion, and the next frame starts only on a new accept.

Verification
REQ-029 DATA_W=8, PARITY_EN=0, accept 8'hA5 -> tx_o = 1,0,1,0,0,1,0,1 over cycles N+1..N+8; tx_last_o=1 only in N+8; in_ready=0 in N+1..N+7 and 1 in N+8.
REQ-030 PARITY_EN=1, accept 8'h07 -> 9 bits 1,1,1,0,0,0,0,0 then parity 1; tx_valid_o high for 9 cycles.
REQ-031 in_valid held at 1 with words 8'h01 then 8'h80 -> 16 contiguous tx_valid_o cycles; second word accepted on the edge ending the first word's last bit; tx_o = 1,0x7 then 0x7,1.
REQ-032 in_valid=1 with 8'hFF during bit 3 of a frame -> no accept until the last-bit edge; current frame bits unchanged; 8'hFF sent next.
REQ-033 Assert reset asynchronously in mid-cycle during bit 4 of a frame -> all outputs 0 before the next clk edge; after deassertion, IDLE with in_ready=1 and no residual bits.
REQ-034 Reset released with in_valid=0 for 5 cycles -> tx_valid_o, busy_o and tx_o stay 0; in_ready stays 1.
